// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: checks mnemonic-level instruction requests, encodes
// them into 32-bit instruction words, buffers them in a small FIFO and
// writes them to consecutive instruction-memory addresses.
module instr_encoder_loader #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_mnem,
    input  logic [3:0]    req_rd,
    input  logic [3:0]    req_rs1,
    input  logic [3:0]    req_rs2,
    input  logic [31:0]   req_imm,
    input  logic          req_last,
    output logic          err_valid,
    output logic [1:0]    err_code,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words_written
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic [AW-1:0]   base_reg;
    logic [AW:0]     reserve_reg, written_reg;
    logic            err_valid_reg;
    logic [1:0]      err_code_reg;

    // decode / check results
    logic [2:0]      opcode;
    logic [1:0]      funct2;
    logic            legal;
    logic            imm_bad;
    logic            exhausted;
    logic [1:0]      req_err_code;
    logic [31:0]     word;
    logic [AW+1:0]   reserve_addr;
    logic            fifo_empty, fifo_full;
    logic            accept, push, pop, start_go;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign req_ready  = (state_reg == LOAD) && !fifo_full;
    assign accept     = req_valid && req_ready;
    assign push       = accept && (req_err_code == 2'b00);
    assign pop        = imem_we && imem_ready;
    assign start_go   = start && ((state_reg == IDLE) || (state_reg == DONE));

    // The next free address is base + reserved words; any carry into bit AW means
    // the instruction memory has no slot left (no wrap-around).
    assign reserve_addr = {2'b00, base_reg} + {1'b0, reserve_reg};
    assign exhausted    = (reserve_addr[AW+1:AW] != 2'b00);

    // Mnemonic table plus immediate range checks.
    always_comb begin
        opcode  = 3'b000;
        funct2  = 2'b00;
        legal   = 1'b1;
        imm_bad = 1'b0;
        case (req_mnem)
            5'd0:  begin opcode = 3'b000; funct2 = 2'b00; end
            5'd1:  begin opcode = 3'b000; funct2 = 2'b01; end
            5'd2:  begin opcode = 3'b000; funct2 = 2'b10; end
            5'd3:  begin opcode = 3'b000; funct2 = 2'b11; end
            5'd4:  begin opcode = 3'b001; funct2 = 2'b00; end
            5'd5:  begin opcode = 3'b001; funct2 = 2'b01; end
            5'd6:  begin opcode = 3'b001; funct2 = 2'b10; end
            5'd7:  begin opcode = 3'b010; funct2 = 2'b00; end
            5'd8:  begin opcode = 3'b010; funct2 = 2'b01; end
            5'd9:  begin opcode = 3'b010; funct2 = 2'b10; end
            5'd10: begin opcode = 3'b011; funct2 = 2'b00; end
            5'd11: begin opcode = 3'b011; funct2 = 2'b01; end
            5'd12: begin opcode = 3'b100; funct2 = 2'b00; end
            5'd13: begin opcode = 3'b100; funct2 = 2'b01; end
            5'd14: begin opcode = 3'b101; funct2 = 2'b00; end
            5'd15: begin opcode = 3'b101; funct2 = 2'b01; end
            5'd16: begin opcode = 3'b101; funct2 = 2'b10; end
            default: legal = 1'b0;
        endcase
        // Every non-R-type carries imm19: bits 31..18 must be pure sign extension.
        if (opcode[2] || opcode[1]) begin
            if (req_imm[31:18] != {14{req_imm[18]}}) imm_bad = 1'b1;
        end
        // Shift amounts are 0..31.
        if ((req_mnem == 5'd8) || (req_mnem == 5'd9)) begin
            if (req_imm[31:5] != 27'd0) imm_bad = 1'b1;
        end
    end

    // Error code with fixed priority: illegal, then immediate, then address space.
    always_comb begin
        req_err_code = 2'b00;
        if (!legal)         req_err_code = 2'b01;
        else if (imm_bad)   req_err_code = 2'b10;
        else if (exhausted) req_err_code = 2'b11;
    end

    // Field packing; C overlaps imm19 so only R-types place a register there.
    always_comb begin
        word        = 32'd0;
        word[31:29] = opcode;
        word[28:27] = funct2;
        case (opcode)
            3'b000, 3'b001: begin
                word[26:23] = req_rd;
                word[22:19] = req_rs1;
                word[18:15] = req_rs2;
            end
            3'b010, 3'b011: begin
                word[26:23] = req_rd;
                word[22:19] = req_rs1;
                word[18:0]  = req_imm[18:0];
            end
            3'b100: begin
                word[26:23] = req_rs2;
                word[22:19] = req_rs1;
                word[18:0]  = req_imm[18:0];
            end
            3'b101: begin
                if (funct2 != 2'b10) begin
                    word[26:23] = req_rs1;
                    word[22:19] = req_rs2;
                end
                word[18:0] = req_imm[18:0];
            end
            default: word = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (accept && req_last) state_next = FLUSH;
            FLUSH: if (fifo_empty) state_next = DONE;
            DONE:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage has no reset; occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= word;
    end

    // FIFO pointers and occupancy; push and pop may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Session base, reserved-slot counter and committed-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg    <= '0;
            reserve_reg <= '0;
            written_reg <= '0;
        end else if (start_go) begin
            base_reg    <= base_addr;
            reserve_reg <= '0;
            written_reg <= '0;
        end else begin
            if (push) reserve_reg <= reserve_reg + 1'b1;
            if (pop)  written_reg <= written_reg + 1'b1;
        end
    end

    // Registered one-cycle error pulse following a rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_reg <= 1'b0;
            err_code_reg  <= 2'b00;
        end else if (accept && (req_err_code != 2'b00)) begin
            err_valid_reg <= 1'b1;
            err_code_reg  <= req_err_code;
        end else begin
            err_valid_reg <= 1'b0;
            err_code_reg  <= 2'b00;
        end
    end

    assign err_valid     = err_valid_reg;
    assign err_code      = err_code_reg;
    assign imem_we       = !fifo_empty;
    assign imem_wdata    = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_reg];
    assign imem_addr     = base_reg + written_reg[AW-1:0];
    assign busy          = (state_reg == LOAD) || (state_reg == FLUSH);
    assign done          = (state_reg == DONE);
    assign words_written = written_reg;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the pipeline's instruction decode path: accepts mnemonic-level instruction requests, checks them, encodes them into 32-bit instruction words and writes them sequentially into instruction memory.
- Sits between the boot/test loader host and the instruction memory write port.
- Internal state: a small FIFO, an address counter and a load FSM.

Parameters:
- DEPTH, 4, encoded-word FIFO depth (power of 2, ≥2).
- AW, 10, instruction memory word-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load session at base_addr.
- base_addr  in  AW  first word address.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_mnem  in  5  mnemonic code.
- req_rd  in  4  destination register.
- req_rs1  in  4  source register 1.
- req_rs2  in  4  source register 2.
- req_imm  in  32  signed immediate / offset.
- req_last  in  1  final request of the session.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 illegal mnemonic, 10 immediate out of range, 11 address space exhausted.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  AW  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD or FLUSH.
- done  out  1  session complete; held until the next start.
- words_written  out  AW+1  words committed this session.

Behaviour:
- Reset: all outputs 0; FSM state IDLE; FIFO emptied; counters cleared. Reset mid-session discards all pending words, with no further writes.
- Mnemonic to {opcode,funct2} mapping:
  - 0–3 addp/subp/mulp/divp → 000,00..11.
  - 4–6 andp/orp/cmpp → 001,00..10.
  - 7–9 addip/sllip/srlip → 010,00..10.
  - 10/11 lb/lw → 011,00/01.
  - 12/13 sb/sw → 100,00/01.
  - 14/15/16 bltp/bgep/jump → 101,00/01/10.
  - Codes 17–31 are illegal.
- Word format: [31:29] opcode, [28:27] funct2, [26:23] A, [22:19] B, [18:15] C, [18:0] imm19 (two's complement). Fields not listed below are 0.
  - R-type (000/001): A=rd, B=rs1, C=rs2; imm unused.
  - 010/011: A=rd, B=rs1, imm19.
  - 100: A=rs2 (data), B=rs1 (base), imm19.
  - bltp/bgep: A=rs1, B=rs2, imm19.
  - jump: imm19 only.
- Immediate checks:
  - 010/011/100/101: req_imm must lie in −262144..262143.
  - sllip/srlip: req_imm must lie in 0..31.
  - Violation → err 10.
- FSM states:
  - IDLE: start → LOAD, latch base_addr, clear words_written and reserve count.
  - LOAD: accept requests. An accepted request with req_last=1 → FLUSH.
  - FLUSH: when the FIFO is empty and no write is pending → DONE.
  - DONE: done=1; start → LOAD.
  - start is ignored in LOAD and FLUSH.
- Request handshake:
  - req_ready = (state==LOAD) && FIFO not full. A pop in the same cycle does not count.
  - Every accepted request completes the handshake, legal or not.
  - Illegal requests are not enqueued. err_valid and err_code are registered and pulse the cycle after acceptance.
  - Error priority: 01 over 10 over 11.
  - req_last on a rejected request still ends LOAD.
- Address exhaustion:
  - The reserve count increments on each enqueue.
  - A legal request with base_addr + reserve count ≥ 2^AW is rejected with err 11. No wrap-around.
- Write path:
  - imem_we = FIFO not empty; imem_wdata = FIFO head; imem_addr = base_addr + words_written.
  - On imem_we && imem_ready: pop, words_written+1.
  - While imem_ready=0, imem_addr and imem_wdata are held stable.
  - Earliest imem_we is the cycle after an accepted legal request (1-cycle latency).
  - Simultaneous push and pop are both performed.

Test Plan:
- start, base_addr=0x010; addp rd=1 rs1=2 rs2=3, last=1; imem_ready=1 → one write, addr 0x010, data 0x00918000; then done=1, words_written=1.
- addip rd=4 rs1=0 imm=−1, then lw rd=5 rs1=6 imm=8 (last) → writes 0x4207FFFF, 0x6AB00008 at consecutive addresses.
- jump imm=16; mnem=20; sllip imm=40; addip imm=262144 → 0xB0000010 written; err 01 for mnem=20, err 10 for the sllip and for the addip; words_written=1.
- imem_ready=0 for 10 cycles, streaming 6 requests → req_ready drops after 4 accepted (DEPTH); addr/data held stable; all 6 written in order after release.
- base_addr=0x3FE, 3 legal requests → writes at 0x3FE and 0x3FF; the third is rejected with err 11.
- Assert rst_n=0 mid-FLUSH with 3 words pending → outputs 0 immediately; no writes after reset release.
